// File: rtl/mul_pkg.sv
// ------------------------------------------------------------------
// mul_pkg: shared FSM states and width helpers, rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // The product and bit-counter widths follow from the operand width.
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_sign_fix.sv
// ------------------------------------------------------------------
// mul_sign_fix: conditional two's-complement negate, rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mul_sign_fix #(
  parameter int W = 16
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? W'(-val_i) : val_i;

endmodule

`default_nettype wire

// File: rtl/seq_shift_add_mul.sv
// ------------------------------------------------------------------
// seq_shift_add_mul: sequential shift-and-add multiplier, rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module seq_shift_add_mul
  import mul_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int              PW   = prod_width(WIDTH);
  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     acc_q;
  logic [PW-1:0]     a_sh_q;
  logic [WIDTH-1:0]  b_sh_q;
  logic              neg_q;
  logic              busy_q;
  logic              done_q;
  logic [PW-1:0]     product_q;

  logic              sgn_d;
  logic              neg_d;
  logic [WIDTH-1:0]  mag_a_d;
  logic [WIDTH-1:0]  mag_b_d;
  logic [PW-1:0]     acc_d;
  logic [PW-1:0]     prod_d;

  assign sgn_d = signed_mode & SIGNED_EN;
  assign neg_d = sgn_d & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);

  mul_sign_fix #(.W(WIDTH)) u_mag_a (
    .neg_i (sgn_d & multiplicand[WIDTH-1]),
    .val_i (multiplicand),
    .val_o (mag_a_d)
  );

  mul_sign_fix #(.W(WIDTH)) u_mag_b (
    .neg_i (sgn_d & multiplier[WIDTH-1]),
    .val_i (multiplier),
    .val_o (mag_b_d)
  );

  mul_sign_fix #(.W(PW)) u_prod_fix (
    .neg_i (neg_q),
    .val_i (acc_q),
    .val_o (prod_d)
  );

  // a_sh_q already holds mag_a << i, so bit i of mag_b is b_sh_q[0].
  assign acc_d = acc_q + (b_sh_q[0] ? a_sh_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= PW'(mag_a_d);
            b_sh_q  <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          a_sh_q <= a_sh_q << 1;
          b_sh_q <= b_sh_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          product_q <= prod_d;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_add_mul.sv
// ------------------------------------------------------------------
// tb_seq_shift_add_mul: directed and random checks of the multiplier
// ------------------------------------------------------------------
`default_nettype none

module tb_seq_shift_add_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // sel 0: WIDTH=16 signed-capable, sel 1: WIDTH=8, sel 2: WIDTH=16 unsigned-only
  logic        st0 = 0, sm0 = 0, st1 = 0, sm1 = 0, st2 = 0, sm2 = 0;
  logic [15:0] a0 = 0, b0 = 0, a2 = 0, b2 = 0;
  logic [7:0]  a1 = 0, b1 = 0;
  logic        busy0, done0, busy1, done1, busy2, done2;
  logic [31:0] p0, p2;
  logic [15:0] p1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seq_shift_add_mul #(.WIDTH(16), .SIGNED_EN(1'b1)) u_dut16 (
    .clk(clk), .rst(rst), .start(st0), .signed_mode(sm0),
    .multiplicand(a0), .multiplier(b0),
    .busy(busy0), .done(done0), .product(p0)
  );

  seq_shift_add_mul #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .start(st1), .signed_mode(sm1),
    .multiplicand(a1), .multiplier(b1),
    .busy(busy1), .done(done1), .product(p1)
  );

  seq_shift_add_mul #(.WIDTH(16), .SIGNED_EN(1'b0)) u_dut16u (
    .clk(clk), .rst(rst), .start(st2), .signed_mode(sm2),
    .multiplicand(a2), .multiplier(b2),
    .busy(busy2), .done(done2), .product(p2)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int width_of(input int sel);
    return (sel == 1) ? 8 : 16;
  endfunction

  // Reference: interpret operands as integers and multiply.
  function automatic logic [31:0] model(input int sel, input logic [15:0] a, b, input logic s);
    int     w;
    bit     sgn;
    longint ma, mb, p;
    w   = width_of(sel);
    sgn = s && (sel != 2);
    ma  = longint'(a) & ((longint'(1) << w) - 1);
    mb  = longint'(b) & ((longint'(1) << w) - 1);
    if (sgn && ma >= (longint'(1) << (w - 1))) ma = ma - (longint'(1) << w);
    if (sgn && mb >= (longint'(1) << (w - 1))) mb = mb - (longint'(1) << w);
    p = ma * mb;
    p = p & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int sel);
    case (sel)
      0:       return p0;
      1:       return {16'h0, p1};
      default: return p2;
    endcase
  endfunction

  task automatic set_in(input int sel, input logic st, input logic s, input logic [15:0] a, b);
    case (sel)
      0:       begin st0 = st; sm0 = s; a0 = a;      b0 = b;      end
      1:       begin st1 = st; sm1 = s; a1 = a[7:0]; b1 = b[7:0]; end
      default: begin st2 = st; sm2 = s; a2 = a;      b2 = b;      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Starts at a negedge, returns at the negedge where done is seen (lat = -1 on timeout).
  task automatic op(input int sel, input logic [15:0] a, b, input logic s, input bit glitch,
                    output int lat, output int bcyc, output bit stable);
    logic [31:0] prev;
    prev   = get_prod(sel);
    lat    = -1;
    bcyc   = 0;
    stable = 1'b1;
    set_in(sel, 1'b1, s, a, b);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) set_in(sel, 1'b0, ~s, 16'($urandom), 16'($urandom));
      if (glitch && (cyc == 3 || cyc == 10)) set_in(sel, 1'b1, ~s, 16'($urandom), 16'($urandom));
      if (glitch && (cyc == 4 || cyc == 11)) set_in(sel, 1'b0, s, 16'($urandom), 16'($urandom));
      if (get_done(sel)) begin
        lat = cyc;
        break;
      end
      if (get_busy(sel)) bcyc++;
      if (get_prod(sel) !== prev) stable = 1'b0;
    end
  endtask

  function automatic logic [15:0] pick(input int w);
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0:       v = 16'h0;
      1:       v = 16'hFFFF;
      2:       v = 16'(1 << (w - 1));
      3:       v = 16'h1;
      default: v = 16'($urandom);
    endcase
    return (w == 8) ? {8'h0, v[7:0]} : v;
  endfunction

  typedef struct {
    int          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] exp;
  } vec_t;

  vec_t dirq[$];

  task automatic add(input int sel, input logic [15:0] a, b, input logic s, input logic [31:0] exp);
    vec_t v;
    v.sel = sel; v.a = a; v.b = b; v.s = s; v.exp = exp;
    dirq.push_back(v);
  endtask

  initial begin
    int          lat, bcyc, dcount;
    bit          stable;
    logic [15:0] ra, rb;
    logic        rs;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_busy%0d", s), 64'(get_busy(s)), 64'd0);
      chk($sformatf("rst_done%0d", s), 64'(get_done(s)), 64'd0);
      chk($sformatf("rst_prod%0d", s), 64'(get_prod(s)), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    op(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat, bcyc, stable);
    chk("ff_lat", 64'(lat), 64'd18);
    chk("ff_busy_cycles", 64'(bcyc), 64'd17);
    chk("ff_prod", 64'(p0), 64'hFFFE0001);
    @(negedge clk);
    chk("ff_done_width", 64'(done0), 64'd0);
    chk("ff_prod_hold", 64'(p0), 64'hFFFE0001);

    add(0, 16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB);
    add(0, 16'hFFFD, 16'h0007, 1'b0, 32'h0006FFEB);
    add(0, 16'h8000, 16'h8000, 1'b1, 32'h40000000);
    add(0, 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);
    add(0, 16'h0000, 16'h0000, 1'b1, 32'h00000000);
    add(2, 16'hFFFF, 16'h0002, 1'b1, 32'h0001FFFE);
    add(1, 16'h0080, 16'h0080, 1'b1, 32'h00004000);
    add(1, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01);
    add(1, 16'h00FD, 16'h0007, 1'b1, 32'h0000FFEB);
    foreach (dirq[i]) begin
      op(dirq[i].sel, dirq[i].a, dirq[i].b, dirq[i].s, 1'b0, lat, bcyc, stable);
      chk($sformatf("dir%0d_lat", i), 64'(lat), 64'(width_of(dirq[i].sel) + 2));
      chk($sformatf("dir%0d_busy", i), 64'(bcyc), 64'(width_of(dirq[i].sel) + 1));
      chk($sformatf("dir%0d_prod", i), 64'(get_prod(dirq[i].sel)), 64'(dirq[i].exp));
    end

    // Start pulses mid-run must be ignored.
    @(negedge clk);
    op(0, 16'h1234, 16'h5678, 1'b0, 1'b1, lat, bcyc, stable);
    chk("glitch_lat", 64'(lat), 64'd18);
    chk("glitch_stable", 64'(stable), 64'd1);
    chk("glitch_prod", 64'(p0), 64'(model(0, 16'h1234, 16'h5678, 1'b0)));
    dcount = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    chk("glitch_single_done", 64'(dcount), 64'd0);

    // Reset in the eighth RUN cycle aborts the operation.
    set_in(0, 1'b1, 1'b1, 16'hABCD, 16'h1357);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) set_in(0, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_done", 64'(done0), 64'd0);
    chk("abort_prod", 64'(p0), 64'd0);
    dcount = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    op(0, 16'd5, 16'd6, 1'b0, 1'b0, lat, bcyc, stable);
    chk("after_abort_lat", 64'(lat), 64'd18);
    chk("after_abort_prod", 64'(p0), 64'd30);

    // Back-to-back random regression: each op is issued on the previous done cycle.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      for (int n = 0; n < ((s == 2) ? 200 : 1500); n++) begin
        ra = pick(width_of(s));
        rb = pick(width_of(s));
        rs = 1'($urandom_range(0, 1));
        op(s, ra, rb, rs, 1'b0, lat, bcyc, stable);
        chk($sformatf("rnd%0d_%0d_lat", s, n), 64'(lat), 64'(width_of(s) + 2));
        chk($sformatf("rnd%0d_%0d_prod a=%0h b=%0h s=%0d", s, n, ra, rb, rs),
            64'(get_prod(s)), 64'(model(s, ra, rb, rs)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
